// File: rtl/std_addfn_share_arbiter.sv
// Round-robin share of one std_addFN adder among NUM_REQ go/done requesters.
// Latency: add_go 1 cycle after grant, req_done 1 cycle after add_done; losers simply wait with go held.
module std_addfn_share_arbiter #(
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 24,
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = EXP_WIDTH + SIG_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_go,
    input  logic [NUM_REQ-1:0]       req_subOp,
    input  logic [NUM_REQ*WIDTH-1:0] req_left,
    input  logic [NUM_REQ*WIDTH-1:0] req_right,
    output logic [NUM_REQ-1:0]       req_done,
    output logic [WIDTH-1:0]         req_out,
    output logic [4:0]               req_flags,
    output logic                     add_go,
    output logic                     add_subOp,
    output logic [WIDTH-1:0]         add_left,
    output logic [WIDTH-1:0]         add_right,
    input  logic [WIDTH-1:0]         add_out,
    input  logic [4:0]               add_flags,
    input  logic                     add_done
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               mask_vld_q;
    logic               add_go_q;
    logic               sub_q;
    logic [WIDTH-1:0]   left_q, right_q;
    logic [WIDTH-1:0]   out_q;
    logic [4:0]         flags_q;

    logic [NUM_REQ-1:0] eligible;
    logic               found;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   left_arr  [NUM_REQ];
    logic [WIDTH-1:0]   right_arr [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            left_arr[i]  = req_left[i*WIDTH +: WIDTH];
            right_arr[i] = req_right[i*WIDTH +: WIDTH];
        end
    end

    // The requester just served sits out exactly one IDLE cycle so a held go cannot re-win instantly.
    always_comb begin
        eligible = req_go;
        if (mask_vld_q) begin
            eligible[grant_q] = 1'b0;
        end
        found  = 1'b0;
        winner = rr_ptr_q;
        idx    = rr_ptr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = ISSUE;
                    grant_d  = winner;
                    rr_ptr_d = winner;
                end
            end
            ISSUE: begin
                if (add_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
            mask_vld_q <= 1'b0;
            add_go_q   <= 1'b0;
            sub_q      <= 1'b0;
            left_q     <= '0;
            right_q    <= '0;
            out_q      <= '0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            mask_vld_q <= (state_q == RESP);
            add_go_q   <= (state_d == ISSUE);
            if (state_q == IDLE && found) begin
                sub_q   <= req_subOp[winner];
                left_q  <= left_arr[winner];
                right_q <= right_arr[winner];
            end
            if (state_q == ISSUE && add_done) begin
                out_q   <= add_out;
                flags_q <= add_flags;
            end
        end
    end

    always_comb begin
        req_done = '0;
        if (state_q == RESP) begin
            req_done[grant_q] = 1'b1;
        end
    end

    assign add_go    = add_go_q;
    assign add_subOp = sub_q;
    assign add_left  = left_q;
    assign add_right = right_q;
    assign req_out   = out_q;
    assign req_flags = flags_q;

    a_done_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_done));
    a_go_matches_issue: assert property (@(posedge clk) disable iff (reset) add_go == (state_q == ISSUE));

endmodule

// File: tb/tb_std_addfn_share_arbiter.sv
// Bench for std_addfn_share_arbiter: directed table, corner sequences, random traffic vs a transaction model.
// The shared adder is a stand-in with programmable latency and a fixed result function.
module tb_std_addfn_share_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic [N-1:0]   req_go, req_subOp, req_done;
    logic [N*W-1:0] req_left, req_right;
    logic [W-1:0]   req_out, add_left, add_right, add_out;
    logic [4:0]     req_flags, add_flags;
    logic           add_go, add_subOp, add_done;

    std_addfn_share_arbiter #(.EXP_WIDTH(8), .SIG_WIDTH(24), .NUM_REQ(N)) dut (
        .clk(clk), .reset(reset),
        .req_go(req_go), .req_subOp(req_subOp), .req_left(req_left), .req_right(req_right),
        .req_done(req_done), .req_out(req_out), .req_flags(req_flags),
        .add_go(add_go), .add_subOp(add_subOp), .add_left(add_left), .add_right(add_right),
        .add_out(add_out), .add_flags(add_flags), .add_done(add_done)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Adder stand-in: the two real-valued cases, otherwise an arbitrary deterministic mix.
    function automatic logic [W+4:0] fake_add(input logic [W-1:0] l, input logic [W-1:0] r, input logic s);
        logic [W-1:0] o;
        if (!s && l == 32'h3F800000 && r == 32'h40000000) return {32'h40400000, 5'd0};
        if (s && l == 32'h40400000 && r == 32'h3F800000) return {32'h40000000, 5'd0};
        o = s ? (l - r) : (l + r);
        o = o ^ 32'h00A5_0000;
        return {o, o[4:0] ^ {4'd0, s}};
    endfunction

    // requesters
    logic [N-1:0] go_v, sub_v, keep_v;
    logic [W-1:0] l_v [N];
    logic [W-1:0] r_v [N];
    logic         rst_v;
    // adder stand-in
    int add_cnt, add_lat, fixed_lat;
    bit rand_mode, spur_mode;
    // transaction model
    bit           m_busy, m_resp;
    int           m_win, m_last, m_mask;
    logic [W-1:0] m_l, m_r;
    logic         m_s;
    logic         e_go;
    logic [N-1:0] e_done;
    logic [W-1:0] e_out;
    logic [4:0]   e_flags;
    // observations
    int           cyc;
    logic [N-1:0] seen_done;
    int           grant_log[$];
    int           served[N];

    task automatic model_reset();
        m_busy = 0; m_resp = 0; m_mask = -1; m_last = N - 1; m_win = 0;
        m_l = '0; m_r = '0; m_s = 1'b0;
        e_go = 1'b0; e_done = '0; e_out = '0; e_flags = '0;
    endtask

    task automatic step();
        logic [W+4:0] f;
        int win;
        @(negedge clk);
        cyc++;
        chk("add_go", {63'd0, add_go}, {63'd0, e_go});
        chk("req_done", {60'd0, req_done}, {60'd0, e_done});
        chk("req_out", {32'd0, req_out}, {32'd0, e_out});
        chk("req_flags", {59'd0, req_flags}, {59'd0, e_flags});
        if (e_go) begin
            chk("add_left", {32'd0, add_left}, {32'd0, m_l});
            chk("add_right", {32'd0, add_right}, {32'd0, m_r});
            chk("add_subOp", {63'd0, add_subOp}, {63'd0, m_s});
        end
        seen_done = req_done;
        for (int i = 0; i < N; i++) begin
            if (req_done[i]) begin
                served[i]++;
                if (!keep_v[i]) go_v[i] = 1'b0;
                else if (rand_mode) begin
                    sub_v[i] = 1'($urandom); l_v[i] = $urandom; r_v[i] = $urandom;
                end
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!go_v[i] && $urandom_range(3) == 0) begin
                    go_v[i] = 1'b1; sub_v[i] = 1'($urandom); l_v[i] = $urandom; r_v[i] = $urandom;
                    keep_v[i] = ($urandom_range(3) == 0);
                end else if (go_v[i] && m_busy && m_win == i && $urandom_range(7) == 0) begin
                    go_v[i] = 1'b0;
                end
            end
            rst_v = ($urandom_range(249) == 0);
        end
        if (rst_v) begin
            add_cnt = 0; add_done = 1'b0;
        end else if (add_go) begin
            if (add_cnt == add_lat) begin
                f = fake_add(add_left, add_right, add_subOp);
                add_done = 1'b1; add_out = f[W+4:5]; add_flags = f[4:0];
            end else begin
                add_cnt++; add_done = 1'b0; add_out = $urandom; add_flags = 5'($urandom);
            end
        end else begin
            add_cnt = 0;
            add_lat = rand_mode ? int'($urandom_range(4)) : fixed_lat;
            add_done = spur_mode && ($urandom_range(3) == 0);
            add_out = $urandom; add_flags = 5'($urandom);
        end
        reset = rst_v; req_go = go_v; req_subOp = sub_v;
        for (int i = 0; i < N; i++) begin
            req_left[i*W +: W] = l_v[i];
            req_right[i*W +: W] = r_v[i];
        end
        // model: what the next cycle must look like
        if (rst_v) begin
            model_reset();
            go_v = '0;
        end else if (m_resp) begin
            m_resp = 0; m_mask = m_win; e_done = '0; e_go = 1'b0;
        end else if (m_busy) begin
            if (add_done) begin
                f = fake_add(m_l, m_r, m_s);
                m_busy = 0; m_resp = 1; e_go = 1'b0;
                e_out = f[W+4:5]; e_flags = f[4:0];
                e_done = '0; e_done[m_win] = 1'b1;
            end else begin
                e_go = 1'b1;
            end
        end else begin
            win = -1;
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_last + k) % N;
                if (win < 0 && go_v[j] && j != m_mask) win = j;
            end
            m_mask = -1;
            if (win >= 0) begin
                m_win = win; m_last = win; m_l = l_v[win]; m_r = r_v[win]; m_s = sub_v[win];
                m_busy = 1; e_go = 1'b1;
                grant_log.push_back(win);
            end else begin
                e_go = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        go_v = '0; keep_v = '0; rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        step();
        chk("rst_add_left", {32'd0, add_left}, 64'd0);
        chk("rst_add_right", {32'd0, add_right}, 64'd0);
        chk("rst_add_subOp", {63'd0, add_subOp}, 64'd0);
        grant_log.delete();
        for (int i = 0; i < N; i++) served[i] = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        keep_v = '0;
        while ((go_v != '0 || m_busy || m_resp) && n < 300) begin
            step(); n++;
        end
        chk("drain_timeout", {63'd0, (n >= 300)}, 64'd0);
    endtask

    typedef struct {
        int           idx;
        logic         sub;
        logic [W-1:0] l, r;
        int           lat;
        logic [W-1:0] exp_out;
        logic [4:0]   exp_flags;
        int           exp_cyc;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int n, d;
        tbl[0] = '{0, 1'b0, 32'h3F800000, 32'h40000000, 2, 32'h40400000, 5'h00, 4};
        tbl[1] = '{2, 1'b1, 32'h40400000, 32'h3F800000, 2, 32'h40000000, 5'h00, 4};
        tbl[2] = '{1, 1'b0, 32'h00000010, 32'h00000001, 0, 32'h00A50011, 5'h11, 2};
        tbl[3] = '{3, 1'b1, 32'h00000100, 32'h00000001, 5, 32'h00A500FF, 5'h1E, 7};

        go_v = '0; sub_v = '0; keep_v = '0; rst_v = 1'b0;
        for (int i = 0; i < N; i++) begin l_v[i] = '0; r_v[i] = '0; served[i] = 0; end
        add_cnt = 0; add_lat = 2; fixed_lat = 2; rand_mode = 0; spur_mode = 0;
        cyc = 0; seen_done = '0;
        reset = 1'b1; req_go = '0; req_subOp = '0; req_left = '0; req_right = '0;
        add_done = 1'b0; add_out = '0; add_flags = '0;
        repeat (2) @(posedge clk);
        model_reset();
        step();
        chk("rst_add_left", {32'd0, add_left}, 64'd0);
        chk("rst_add_subOp", {63'd0, add_subOp}, 64'd0);

        // directed single requests
        foreach (tbl[t]) begin
            fixed_lat = tbl[t].lat;
            l_v[tbl[t].idx] = tbl[t].l; r_v[tbl[t].idx] = tbl[t].r; sub_v[tbl[t].idx] = tbl[t].sub;
            go_v[tbl[t].idx] = 1'b1;
            cyc = -1;
            step();
            n = 0;
            do begin step(); n++; end while (seen_done == '0 && n < 30);
            chk("single_timeout", {63'd0, (n >= 30)}, 64'd0);
            chk("single_done_cycle", 64'(cyc), 64'(tbl[t].exp_cyc));
            chk("single_done_vec", {60'd0, seen_done}, 64'(1 << tbl[t].idx));
            chk("single_out", {32'd0, req_out}, {32'd0, tbl[t].exp_out});
            chk("single_flags", {59'd0, req_flags}, {59'd0, tbl[t].exp_flags});
            repeat (3) step();
        end

        // contention 0,1,3 right after reset
        do_reset();
        fixed_lat = 1;
        l_v[0] = 32'h3F800000; r_v[0] = 32'h40000000; sub_v[0] = 1'b0;
        l_v[1] = 32'h00001234; r_v[1] = 32'h00000022; sub_v[1] = 1'b1;
        l_v[3] = 32'h40400000; r_v[3] = 32'h3F800000; sub_v[3] = 1'b1;
        go_v = 4'b1011;
        n = 0;
        while ((served[0] + served[1] + served[3]) < 3 && n < 60) begin step(); n++; end
        repeat (3) step();
        chk("cont_grants", 64'(grant_log.size()), 64'd3);
        if (grant_log.size() == 3) begin
            chk("cont_first", 64'(grant_log[0]), 64'd0);
            chk("cont_second", 64'(grant_log[1]), 64'd1);
            chk("cont_third", 64'(grant_log[2]), 64'd3);
        end
        chk("cont_once0", 64'(served[0]), 64'd1);
        chk("cont_once1", 64'(served[1]), 64'd1);
        chk("cont_none2", 64'(served[2]), 64'd0);
        chk("cont_once3", 64'(served[3]), 64'd1);

        // fairness with all requests held
        do_reset();
        fixed_lat = 0;
        keep_v = '1; go_v = '1;
        n = 0;
        while (grant_log.size() < 8 && n < 100) begin step(); n++; end
        chk("fair_timeout", {63'd0, (n >= 100)}, 64'd0);
        for (int k = 0; k < 8 && k < grant_log.size(); k++) chk("fair_order", 64'(grant_log[k]), 64'(k % N));
        drain();

        // masking of the just-served requester
        do_reset();
        fixed_lat = 1;
        keep_v[2] = 1'b1; go_v[2] = 1'b1; l_v[2] = 32'h55; r_v[2] = 32'h3; sub_v[2] = 1'b0;
        n = 0;
        while (served[2] == 0 && n < 30) begin step(); n++; end
        d = cyc;
        step();
        chk("mask_go_d1", {63'd0, add_go}, 64'd0);
        step();
        chk("mask_go_d2", {63'd0, add_go}, 64'd0);
        step();
        chk("mask_regrant", {63'd0, add_go}, 64'd1);
        chk("mask_gap", 64'(cyc - d), 64'd3);
        chk("mask_grants", 64'(grant_log.size()), 64'd2);
        drain();

        // reset in the second add_go cycle
        do_reset();
        fixed_lat = 5;
        go_v[3] = 1'b1; l_v[3] = 32'h777; r_v[3] = 32'h1; sub_v[3] = 1'b0;
        step();
        step();
        chk("rmid_go1", {63'd0, add_go}, 64'd1);
        rst_v = 1'b1;
        step();
        chk("rmid_go2", {63'd0, add_go}, 64'd1);
        rst_v = 1'b0;
        step();
        chk("rmid_go_after", {63'd0, add_go}, 64'd0);
        chk("rmid_done_after", {60'd0, req_done}, 64'd0);
        repeat (8) step();
        chk("rmid_dropped", 64'(served[3]), 64'd0);
        fixed_lat = 2;
        go_v[1] = 1'b1; l_v[1] = 32'h3F800000; r_v[1] = 32'h40000000; sub_v[1] = 1'b0;
        n = 0;
        do begin step(); n++; end while (seen_done == '0 && n < 30);
        chk("rmid_fresh_vec", {60'd0, seen_done}, 64'd2);
        chk("rmid_fresh_out", {32'd0, req_out}, 64'h40400000);

        // randomized traffic against the model
        rand_mode = 1; spur_mode = 1;
        repeat (2000) step();
        rand_mode = 0; spur_mode = 0; rst_v = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
